// File: rtl/ls_pkg.sv
// Shared encodings for the load/store micro-sequencer: FSM states, opcodes,
// ALU function selects and write-back source selects.
package ls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } ls_state_t;

  localparam logic       OP_LW     = 1'b0;
  localparam logic       OP_SW     = 1'b1;

  localparam logic [4:0] FS_PASS_S = 5'h00;
  localparam logic [4:0] FS_ADD    = 5'h02;

  localparam logic [2:0] YSEL_ALU  = 3'd0;
  localparam logic [2:0] YSEL_DY   = 3'd3;

endpackage

// File: rtl/ls_sequencer.sv
// Load/store micro-sequencer: walks the datapath through address generation,
// memory access and (for LW) register write-back for one command at a time.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high, datapath controls parked
// EXEC  | effective address = rs + sext(imm) computed by the ALU
// MEM   | memory strobes held for MEM_CYCLES cycles
// WB    | LW only: memory read data written to rt
module ls_sequencer
  import ls_pkg::*;
#(
  parameter int MEM_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [15:0] cmd_imm,
  output logic        busy,
  output logic        done,
  output logic        D_En,
  output logic [4:0]  D_Addr,
  output logic [4:0]  S_Addr,
  output logic [4:0]  T_Addr,
  output logic [31:0] DT,
  output logic        T_Sel,
  output logic [4:0]  FS,
  output logic        HILO_ld,
  output logic [31:0] PC_in,
  output logic [2:0]  Y_Sel,
  output logic        dm_cs,
  output logic        dm_wr,
  output logic        dm_rd
);

  // Counter holds the number of MEM cycles still to follow the current one.
  localparam logic [3:0] MEM_LOAD = 4'(MEM_CYCLES - 1);

  ls_state_t   state, nxt_state;
  logic [3:0]  cnt, nxt_cnt;
  logic        op_q, nxt_op;
  logic [4:0]  rs_q, nxt_rs;
  logic [4:0]  rt_q, nxt_rt;
  logic [15:0] imm_q, nxt_imm;
  logic        nxt_mem, nxt_wb;

  assign cmd_ready = (state == ST_IDLE);
  assign HILO_ld   = 1'b0;
  assign PC_in     = 32'd0;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_op    = op_q;
    nxt_rs    = rs_q;
    nxt_rt    = rt_q;
    nxt_imm   = imm_q;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          nxt_state = ST_EXEC;
          nxt_op    = cmd_op;
          nxt_rs    = cmd_rs;
          nxt_rt    = cmd_rt;
          nxt_imm   = cmd_imm;
        end
      end
      ST_EXEC: begin
        nxt_state = ST_MEM;
        nxt_cnt   = MEM_LOAD;
      end
      ST_MEM: begin
        if (cnt == 4'd0) nxt_state = (op_q == OP_LW) ? ST_WB : ST_IDLE;
        else             nxt_cnt   = cnt - 4'd1;
      end
      ST_WB: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign nxt_mem = (nxt_state == ST_MEM);
  assign nxt_wb  = (nxt_state == ST_WB);

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= 1'b0;
      rs_q   <= '0;
      rt_q   <= '0;
      imm_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D_En   <= 1'b0;
      D_Addr <= '0;
      S_Addr <= '0;
      T_Addr <= '0;
      DT     <= '0;
      T_Sel  <= 1'b0;
      FS     <= FS_PASS_S;
      Y_Sel  <= YSEL_ALU;
      dm_cs  <= 1'b0;
      dm_wr  <= 1'b0;
      dm_rd  <= 1'b0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      op_q   <= nxt_op;
      rs_q   <= nxt_rs;
      rt_q   <= nxt_rt;
      imm_q  <= nxt_imm;
      busy   <= (nxt_state != ST_IDLE);
      S_Addr <= (nxt_state != ST_IDLE) ? nxt_rs : 5'd0;
      T_Addr <= (nxt_state != ST_IDLE) ? nxt_rt : 5'd0;
      DT     <= (nxt_state == ST_EXEC) ? {{16{nxt_imm[15]}}, nxt_imm} : 32'd0;
      T_Sel  <= (nxt_state == ST_EXEC);
      FS     <= (nxt_state == ST_IDLE) ? FS_PASS_S : FS_ADD;
      dm_cs  <= nxt_mem | nxt_wb;
      dm_rd  <= (nxt_mem & (nxt_op == OP_LW)) | nxt_wb;
      dm_wr  <= nxt_mem & (nxt_op == OP_SW);
      Y_Sel  <= nxt_wb ? YSEL_DY : YSEL_ALU;
      D_Addr <= nxt_wb ? nxt_rt : 5'd0;
      D_En   <= nxt_wb & (nxt_rt != 5'd0);
      // SW completes in its last MEM cycle, LW in WB.
      done   <= nxt_wb | (nxt_mem & (nxt_op == OP_SW) & (nxt_cnt == 4'd0));
    end
  end

endmodule

// File: tb/tb_ls_sequencer.sv
// Scoreboard bench for ls_sequencer: two instances (MEM_CYCLES=1 and 3), the
// stimulus pushes per-cycle expected control words, monitors pop and compare.
module tb_ls_sequencer;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic [4:0]  s;
    logic [4:0]  t;
    logic [31:0] dt;
    logic        tsel;
    logic [4:0]  fs;
    logic        den;
    logic [4:0]  daddr;
    logic [2:0]  ysel;
    logic        cs;
    logic        wr;
    logic        rd;
    logic        done;
    logic        hilo;
    logic [31:0] pc;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid1, cmd_valid3;
  logic        cmd_op;
  logic [4:0]  cmd_rs, cmd_rt;
  logic [15:0] cmd_imm;

  logic        ready1, busy1, done1, den1, tsel1, hilo1, cs1, wr1, rd1;
  logic [4:0]  daddr1, s1, t1, fs1;
  logic [31:0] dt1, pc1;
  logic [2:0]  ysel1;
  logic        ready3, busy3, done3, den3, tsel3, hilo3, cs3, wr3, rd3;
  logic [4:0]  daddr3, s3, t3, fs3;
  logic [31:0] dt3, pc3;
  logic [2:0]  ysel3;

  rec_t act1, act3;
  rec_t q1[$], q3[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ls_sequencer #(.MEM_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(ready1),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
    .busy(busy1), .done(done1), .D_En(den1), .D_Addr(daddr1), .S_Addr(s1),
    .T_Addr(t1), .DT(dt1), .T_Sel(tsel1), .FS(fs1), .HILO_ld(hilo1),
    .PC_in(pc1), .Y_Sel(ysel1), .dm_cs(cs1), .dm_wr(wr1), .dm_rd(rd1));

  ls_sequencer #(.MEM_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(ready3),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
    .busy(busy3), .done(done3), .D_En(den3), .D_Addr(daddr3), .S_Addr(s3),
    .T_Addr(t3), .DT(dt3), .T_Sel(tsel3), .FS(fs3), .HILO_ld(hilo3),
    .PC_in(pc3), .Y_Sel(ysel3), .dm_cs(cs3), .dm_wr(wr3), .dm_rd(rd3));

  assign act1 = {ready1, busy1, s1, t1, dt1, tsel1, fs1, den1, daddr1, ysel1,
                 cs1, wr1, rd1, done1, hilo1, pc1};
  assign act3 = {ready3, busy3, s3, t3, dt3, tsel3, fs3, den3, daddr3, ysel3,
                 cs3, wr3, rd3, done3, hilo3, pc3};

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input rec_t act, input rec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int inst, input rec_t r);
    if (inst == 1) q1.push_back(r);
    else           q3.push_back(r);
  endtask

  // Expected control words, one per busy cycle, derived from the command.
  task automatic push_cmd(input int inst, input bit op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [15:0] imm, input int mc);
    rec_t r;
    r = '0; r.busy = 1; r.s = rs; r.t = rt; r.fs = 5'h02;
    r.dt = {{16{imm[15]}}, imm}; r.tsel = 1;
    push(inst, r);
    for (int i = 1; i <= mc; i++) begin
      r = '0; r.busy = 1; r.s = rs; r.t = rt; r.fs = 5'h02; r.cs = 1;
      r.rd = !op; r.wr = op; r.done = op && (i == mc);
      push(inst, r);
    end
    if (!op) begin
      r = '0; r.busy = 1; r.s = rs; r.t = rt; r.fs = 5'h02; r.cs = 1; r.rd = 1;
      r.ysel = 3'd3; r.daddr = rt; r.den = (rt != 5'd0); r.done = 1;
      push(inst, r);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy1) begin
        if (q1.size() == 0) check("inst1 unexpected busy", act1, idle_rec());
        else                check("inst1 cycle", act1, q1.pop_front());
      end else check("inst1 idle", act1, idle_rec());
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy3) begin
        if (q3.size() == 0) check("inst3 unexpected busy", act3, idle_rec());
        else                check("inst3 cycle", act3, q3.pop_front());
      end else check("inst3 idle", act3, idle_rec());
    end
  end

  // Present a command and wait for its handshake; called just after a posedge.
  task automatic issue(input int inst, input bit op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm,
                       input bit keep_valid, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    if (inst == 1) cmd_valid1 = 1'b1;
    else           cmd_valid3 = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((inst == 1) ? ready1 : ready3) begin
        push_cmd(inst, op, rs, rt, imm, (inst == 1) ? 1 : 3);
        got = 1;
      end
      @(posedge clk); #1;
    end
    if (got) acc_cyc = cyc;
    else begin
      n_vec++; n_err++;
      $display("FAIL handshake timeout inst%0d: got no cmd_ready required cmd_ready=1", inst);
    end
    if (!keep_valid) begin
      cmd_valid1 = 1'b0;
      cmd_valid3 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int inst);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk); #2;
      if (inst == 1) ok = !busy1 && (q1.size() == 0);
      else           ok = !busy3 && (q3.size() == 0);
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL completion timeout inst%0d: got busy/pending required idle", inst);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, prev;
    bit op;
    reset = 1'b1;
    cmd_valid1 = 1'b1; cmd_valid3 = 1'b1;
    cmd_op = 1'b0; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_imm = 16'h1234;

    // Reset with cmd_valid high: must stay idle, nothing accepted.
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(1, 1'b0, 5'd5, 5'd9, 16'hFFFC, 1'b0, acc);
    wait_idle(1);
    issue(3, 1'b1, 5'd2, 5'd7, 16'h0010, 1'b0, acc);
    wait_idle(3);
    issue(1, 1'b0, 5'd3, 5'd0, 16'h0004, 1'b0, acc);
    wait_idle(1);
    issue(3, 1'b0, 5'd1, 5'd31, 16'h8000, 1'b0, acc);
    wait_idle(3);
    issue(1, 1'b1, 5'd30, 5'd17, 16'h7FFF, 1'b0, acc);
    wait_idle(1);

    // Reset during the 2nd MEM cycle of an SW on the 3-cycle instance.
    issue(3, 1'b1, 5'd4, 5'd6, 16'h0020, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q3.delete();
    repeat (2) @(posedge clk);
    #1;
    issue(3, 1'b0, 5'd7, 5'd12, 16'h0100, 1'b0, acc);
    wait_idle(3);

    // cmd_valid held high with alternating LW/SW; fields change while busy.
    prev = -1;
    op = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(1, op, 5'(i + 1), 5'(i + 10), 16'(16'h0F00 + i), 1'b1, acc);
      if (prev >= 0) begin
        n_vec++;
        if ((acc - prev) != (op ? 4 : 3)) begin
          n_err++;
          $display("FAIL command period after %s: got %0d required %0d",
                   op ? "LW" : "SW", acc - prev, op ? 4 : 3);
        end
      end
      prev = acc;
      op = ~op;
    end
    cmd_valid1 = 1'b0;
    wait_idle(1);
    repeat (3) @(posedge clk);
    #1;

    n_vec++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d/%0d pending required 0/0",
               q1.size(), q3.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ls_sequencer.md
# ls_sequencer

Load/store micro-sequencer that drives the control inputs of the integer datapath and data memory top level: the datapath register-file, ALU-select and memory-strobe pins. It accepts one load-word or store-word command at a time over a valid/ready handshake. It then steps the datapath through address generation, memory access and (for loads) register write-back, and pulses `done` when the access completes. It replaces manual testbench driving of those control pins and is the first piece of the multi-cycle control unit.

## Interface
Parameters:
- `MEM_CYCLES`, default 1: number of cycles the MEM state holds the memory strobes (legal range 1–15).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: sequencer idle, command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op` in 1: 0 = LW, 1 = SW.
- `cmd_rs` in 5: base register.
- `cmd_rt` in 5: LW destination register / SW source register.
- `cmd_imm` in 16: signed offset.
- `busy` out 1: high in any non-IDLE state.
- `done` out 1: one-cycle completion pulse.
- `D_En` out 1: register-file write enable.
- `D_Addr` out 5: write register.
- `S_Addr` out 5: S read register.
- `T_Addr` out 5: T read register.
- `DT` out 32: immediate into datapath.
- `T_Sel` out 1: ALU B-operand select (1 = DT).
- `FS` out 5: ALU function select.
- `HILO_ld` out 1: held 0.
- `PC_in` out 32: held 0.
- `Y_Sel` out 3: write-back source select.
- `dm_cs` out 1: data memory chip select.
- `dm_wr` out 1: data memory write strobe.
- `dm_rd` out 1: data memory read strobe.

## Operation
- States: IDLE, EXEC, MEM, WB.
- IDLE:
  - `cmd_ready`=1; all datapath/memory outputs 0.
  - On handshake, latch op/rs/rt/imm into command registers and go to EXEC.
- EXEC (1 cycle):
  - `S_Addr`=rs, `T_Sel`=1, `DT`=sign-extended imm (bit 15 replicated into 31:16), `FS`=FS_ADD, `T_Addr`=rt.
  - The datapath registers the effective address and the T read data at the end of this cycle.
  - Next state: MEM.
- MEM (`MEM_CYCLES` cycles, down-counter loaded on EXEC→MEM):
  - `dm_cs`=1.
  - LW: `dm_rd`=1, `dm_wr`=0.
  - SW: `dm_wr`=1, `dm_rd`=0.
  - `S_Addr`/`T_Addr` held from EXEC.
  - At count expiry: LW → WB; SW → IDLE, with `done`=1 during the final MEM cycle.
- WB (LW only, 1 cycle):
  - `dm_cs`=1, `dm_rd`=1 (read data stays valid), `Y_Sel`=YSEL_DY, `D_Addr`=rt.
  - `D_En`=1 unless rt=0, in which case `D_En`=0 and `done` still pulses.
  - `done`=1. Next state: IDLE.
- `dm_wr` and `dm_rd` are never high in the same cycle. `dm_wr` is never high outside MEM.
- `Y_Sel`=YSEL_ALU in every state except WB. `FS`=FS_ADD in every non-IDLE state; `FS`=FS_PASS_S in IDLE.
- `cmd_valid` while not idle is ignored: no queueing, and command fields are not re-sampled.

## Timing
- All outputs are registered (Moore, decoded from next-state at the clock edge). There are no combinational input→output paths except `cmd_ready`, which equals (state==IDLE).
- Reset: state=IDLE, counter=0, command registers=0, every output 0 except `cmd_ready`=1.
- Handshake at edge t0 gives:
  - EXEC in cycle t0+1.
  - MEM in cycles t0+2 … t0+1+MEM_CYCLES.
  - LW: WB/`done` in cycle t0+2+MEM_CYCLES.
  - SW: `done` in cycle t0+1+MEM_CYCLES.
- Command rate: one cycle in IDLE separates consecutive commands. The minimum command period is MEM_CYCLES+3 cycles for LW and MEM_CYCLES+2 cycles for SW.
- Reset asserted mid-operation: at the next edge the sequencer is in IDLE with all strobes 0. `done` is not pulsed. A partially strobed SW may already have written memory, which is acceptable.
- `reset` and `cmd_valid` high in the same cycle: reset wins, and the command is not accepted.

## Structure
- Package `ls_pkg`:
  - State enum encoding IDLE=2'd0, EXEC=2'd1, MEM=2'd2, WB=2'd3.
  - OP_LW=1'b0, OP_SW=1'b1.
  - FS_PASS_S=5'h00, FS_ADD=5'h02.
  - YSEL_ALU=3'd0, YSEL_DY=3'd3.
- Single module, no sub-module. The MEM wait counter is a 4-bit register local to the FSM.
- Integration: `Datapath_Top` control pins are driven from this block in the next-level top.

## Test plan
- Reset with `cmd_valid`=1: `cmd_ready`=1, `busy`=0, all strobes 0, and no command is accepted while reset is high.
- LW rs=5, rt=9, imm=16'hFFFC, MEM_CYCLES=1:
  - EXEC cycle shows `S_Addr`=5, `DT`=32'hFFFF_FFFC, `T_Sel`=1, `FS`=FS_ADD.
  - Next cycle `dm_cs`=`dm_rd`=1.
  - Next cycle `D_En`=1, `D_Addr`=9, `Y_Sel`=3, `done`=1.
  - `cmd_ready` returns the following cycle.
- SW rs=2, rt=7, imm=16'h0010, MEM_CYCLES=3: `dm_cs`=`dm_wr`=1 for exactly 3 cycles with `T_Addr`=7, `done` in the 3rd cycle, and `D_En` never high.
- LW rt=0: full sequence runs, `D_En` stays 0 throughout, and `done` pulses once.
- Reset pulsed during the 2nd MEM cycle of an SW (MEM_CYCLES=3): next cycle IDLE, `dm_wr`=0, no `done`. A new LW issued afterwards completes normally.
- `cmd_valid` held high continuously with alternating LW/SW: each command is accepted only when `cmd_ready`=1, the period is 4 cycles (LW) / 3 cycles (SW) at MEM_CYCLES=1, and the `dm_rd` & `dm_wr` overlap assertion is never violated.
